fhn_array: RTL and testbench
============================

Name: fhn_array

Overview:
- Time-multiplexed array of NUM_CH FitzHugh-Nagumo neurons sharing one forward-Euler datapath.
- Successor to the single-neuron `core`. Adds:
  - parametrised width, fraction bits and channel count;
  - a per-channel stimulus register file;
  - a start/busy/done sweep handshake;
  - a per-sample output stream with upward-crossing spike detection.
- Sits between the stimulus/host interface and the downstream spike/trace logger.

Parameters:
- WIDTH, 16, signed fixed-point word width for v, w and stimulus.
- FRAC, 12, fraction bits (Q4.12 by default).
- NUM_CH, 8, number of neurons (≥1); CH_W = max(1, clog2(NUM_CH)).
- DT_SHIFT, 4, Euler step dt = 2^-DT_SHIFT.
- A_Q, 2867, parameter a = 0.7 in Q(FRAC).
- B_Q, 3277, parameter b = 0.8.
- EPS_Q, 328, parameter eps = 0.08.
- THIRD_Q, 1365, 1/3.
- V_TH, 2048, spike threshold on v (0.5).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request one sweep over all channels.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- i_wr_en  in  1  stimulus write strobe.
- i_wr_addr  in  CH_W  stimulus channel index.
- i_wr_data  in  WIDTH  signed stimulus, Q(FRAC).
- out_valid  out  1  one-cycle pulse, sample valid.
- out_ch  out  CH_W  channel of the sample.
- v_out  out  WIDTH  updated v.
- w_out  out  WIDTH  updated w.
- spike  out  1  upward threshold crossing on this sample.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - v, w and stimulus are 0 for all channels;
  - FSM in IDLE;
  - busy, done, out_valid, spike, out_ch, v_out and w_out are all 0.
  - Reset mid-sweep aborts the sweep: no done, no further out_valid.
- FSM states: IDLE → LOAD → MUL1 → MUL2 → UPD → WB → (next channel: LOAD | last: DONE) → IDLE.
- start:
  - sampled only in IDLE; ignored while busy.
  - The channel counter is reset to 0 on acceptance.
- Timing, counting the start-sampling cycle as 0:
  - channel k's WB state is cycle 5k+5; out_valid is high in that cycle only;
  - done is high in cycle 5N+1;
  - busy is high in cycles 1..5N+1.
- LOAD: latch v[k], w[k] and I[k].
  - A same-cycle stimulus write to k is bypassed, so the new value is used.
  - Writes are accepted in any state; out-of-range addresses are ignored.
- Arithmetic:
  - Intermediates are signed 3*WIDTH.
  - Every product is followed by `>>> FRAC` (arithmetic shift, floor).
  - MUL1: sq = v*v; bw = B_Q*w.
  - MUL2: cube = sq*v; c3 = cube*THIRD_Q.
  - UPD:
    - dv = v − c3 − w + I;
    - dw = EPS_Q*(v + A_Q − bw);
    - v' = sat(v + (dv >>> DT_SHIFT));
    - w' = sat(w + (dw >>> DT_SHIFT)).
  - sat clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Only the final results are saturated.
- WB:
  - write back v', w' for channel k;
  - drive out_ch = k, v_out = v', w_out = w';
  - spike = (v ≥ V_TH is false for old v) AND (v' ≥ V_TH). This is signed compare, one pulse per upward crossing.
- Between samples, v_out, w_out and out_ch hold their last value; spike is 0 when out_valid is 0.
- NUM_CH=1 is legal: done is in cycle 6.

Optional Feature:
- Macro: FHN_SAT_STICKY_EN.
- Defined:
  - adds output port sat_flag (1 bit);
  - set in WB when either v' or w' was clamped;
  - stays set until reset (reset value 0).
- Undefined: the port and its logic are absent; saturation behaviour is otherwise identical.

Decomposition:
- Package fhn_pkg holds:
  - Q-format defaults: FRAC, A_Q, B_Q, EPS_Q, THIRD_Q;
  - the FSM state enum (IDLE, LOAD, MUL1, MUL2, UPD, WB, DONE);
  - the sat function.
- Sub-module fhn_euler_step: the registered MUL1/MUL2/UPD datapath. Inputs v, w, I; outputs v', w' and sat bits.
- fhn_array owns the FSM, the state/stimulus register files and the output stage.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → busy/done/out_valid = 0; the first sweep with I=0 gives ch0 v_out=0, w_out=14.
  - Derivation: dw = 328*2867 >>> 12 = 229; 229 >>> 4 = 14.
- Stimulus: write I[1]=4096 then start (NUM_CH=8) → out_valid at cycles 5,10,…,40.
  - ch1 gives v_out=256, w_out=14; other channels give v=0, w=14.
  - done at cycle 41; busy low at cycle 42.
- Start while busy: pulse start at cycle 12 → ignored, exactly 8 out_valid pulses; then start immediately after done → second sweep begins normally.
- Write bypass: write I[3]=4096 in ch3's LOAD cycle (cycle 16) → ch3 v_out=256 in that sweep.
- Spike: I[0]=4096, 400 back-to-back sweeps checked against a bit-accurate model → spike only on samples where v crosses 2048 upward, and never on consecutive samples above threshold.
- Reset mid-sweep: rst_n=0 at cycle 20 → no done; all outputs 0; the next sweep reproduces the reset-test values. With FHN_SAT_STICKY_EN: I=32767 for 50 sweeps → sat_flag rises when the model first clamps, then stays high.

Source files
------------

// File: rtl/fhn_pkg.sv
// fhn_pkg: Q-format defaults, FSM state encoding and saturation helper for fhn_array (rev 1.0).
`default_nettype none

package fhn_pkg;

  localparam int DEF_FRAC    = 12;
  localparam int DEF_A_Q     = 2867;
  localparam int DEF_B_Q     = 3277;
  localparam int DEF_EPS_Q   = 328;
  localparam int DEF_THIRD_Q = 1365;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    UPD  = 3'd4,
    WB   = 3'd5,
    DONE = 3'd6
  } state_e;

  // Clamp a wide signed value into the range of a wd-bit signed word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int wd);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wd - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wd - 1));
    if (x > hi) begin
      sat = hi;
    end else if (x < lo) begin
      sat = lo;
    end else begin
      sat = x;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/fhn_if.sv
// fhn_if: sweep handshake, stimulus write port and sample stream of fhn_array (rev 1.0).
`default_nettype none

interface fhn_if #(
  parameter int WIDTH = 16,
  parameter int CH_W  = 3
);

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    i_wr_en;
  logic [CH_W-1:0]         i_wr_addr;
  logic signed [WIDTH-1:0] i_wr_data;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic signed [WIDTH-1:0] v_out;
  logic signed [WIDTH-1:0] w_out;
  logic                    spike;
`ifdef FHN_SAT_STICKY_EN
  logic                    sat_flag;

  modport master (
    output start, i_wr_en, i_wr_addr, i_wr_data,
    input  busy, done, out_valid, out_ch, v_out, w_out, spike, sat_flag
  );

  modport slave (
    input  start, i_wr_en, i_wr_addr, i_wr_data,
    output busy, done, out_valid, out_ch, v_out, w_out, spike, sat_flag
  );
`else
  modport master (
    output start, i_wr_en, i_wr_addr, i_wr_data,
    input  busy, done, out_valid, out_ch, v_out, w_out, spike
  );

  modport slave (
    input  start, i_wr_en, i_wr_addr, i_wr_data,
    output busy, done, out_valid, out_ch, v_out, w_out, spike
  );
`endif

endinterface

`default_nettype wire

// File: rtl/fhn_euler_step.sv
// fhn_euler_step: registered LOAD/MUL1/MUL2/UPD forward-Euler datapath for one FitzHugh-Nagumo neuron (rev 1.0).
`default_nettype none

module fhn_euler_step
  import fhn_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = DEF_FRAC,
  parameter int DT_SHIFT = 4,
  parameter int A_Q      = DEF_A_Q,
  parameter int B_Q      = DEF_B_Q,
  parameter int EPS_Q    = DEF_EPS_Q,
  parameter int THIRD_Q  = DEF_THIRD_Q
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_en,
  input  logic                    mul1_en,
  input  logic                    mul2_en,
  input  logic                    upd_en,
  input  logic signed [WIDTH-1:0] v_in,
  input  logic signed [WIDTH-1:0] w_in,
  input  logic signed [WIDTH-1:0] i_in,
  output logic signed [WIDTH-1:0] v_old,
  output logic signed [WIDTH-1:0] v_new,
  output logic signed [WIDTH-1:0] w_new,
  output logic                    sat_v,
  output logic                    sat_w
);

  localparam int XW = 3 * WIDTH;
  localparam logic signed [XW-1:0] K_A     = XW'(A_Q);
  localparam logic signed [XW-1:0] K_B     = XW'(B_Q);
  localparam logic signed [XW-1:0] K_EPS   = XW'(EPS_Q);
  localparam logic signed [XW-1:0] K_THIRD = XW'(THIRD_Q);

  logic signed [WIDTH-1:0] v_q, v_d, w_q, w_d, i_q, i_d;
  logic signed [WIDTH-1:0] v_new_q, v_new_d, w_new_q, w_new_d;
  logic signed [XW-1:0]    sq_q, sq_d, bw_q, bw_d, c3_q, c3_d;
  logic                    sat_v_q, sat_v_d, sat_w_q, sat_w_d;

  logic signed [XW-1:0] v_x, w_x, i_x, cube, dv, dw, v_sum, w_sum;
  logic signed [63:0]   v_clamped, w_clamped;

  assign v_x   = XW'(v_q);
  assign w_x   = XW'(w_q);
  assign i_x   = XW'(i_q);
  assign cube  = (sq_q * v_x) >>> FRAC;
  assign dv    = v_x - c3_q - w_x + i_x;
  assign dw    = (K_EPS * (v_x + K_A - bw_q)) >>> FRAC;
  assign v_sum = v_x + (dv >>> DT_SHIFT);
  assign w_sum = w_x + (dw >>> DT_SHIFT);

  // Only the final state update is clamped; intermediates are wide enough not to wrap.
  assign v_clamped = sat(64'(v_sum), WIDTH);
  assign w_clamped = sat(64'(w_sum), WIDTH);

  always_comb begin
    v_d     = v_q;
    w_d     = w_q;
    i_d     = i_q;
    sq_d    = sq_q;
    bw_d    = bw_q;
    c3_d    = c3_q;
    v_new_d = v_new_q;
    w_new_d = w_new_q;
    sat_v_d = sat_v_q;
    sat_w_d = sat_w_q;
    if (ld_en) begin
      v_d = v_in;
      w_d = w_in;
      i_d = i_in;
    end
    if (mul1_en) begin
      sq_d = (v_x * v_x) >>> FRAC;
      bw_d = (K_B * w_x) >>> FRAC;
    end
    if (mul2_en) begin
      c3_d = (cube * K_THIRD) >>> FRAC;
    end
    if (upd_en) begin
      v_new_d = WIDTH'(v_clamped);
      w_new_d = WIDTH'(w_clamped);
      sat_v_d = (v_clamped != 64'(v_sum));
      sat_w_d = (w_clamped != 64'(w_sum));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q     <= '0;
      w_q     <= '0;
      i_q     <= '0;
      sq_q    <= '0;
      bw_q    <= '0;
      c3_q    <= '0;
      v_new_q <= '0;
      w_new_q <= '0;
      sat_v_q <= 1'b0;
      sat_w_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      w_q     <= w_d;
      i_q     <= i_d;
      sq_q    <= sq_d;
      bw_q    <= bw_d;
      c3_q    <= c3_d;
      v_new_q <= v_new_d;
      w_new_q <= w_new_d;
      sat_v_q <= sat_v_d;
      sat_w_q <= sat_w_d;
    end
  end

  assign v_old = v_q;
  assign v_new = v_new_q;
  assign w_new = w_new_q;
  assign sat_v = sat_v_q;
  assign sat_w = sat_w_q;

endmodule

`default_nettype wire

// File: rtl/fhn_array.sv
// fhn_array: NUM_CH FitzHugh-Nagumo neurons time-multiplexed over one Euler datapath (rev 1.0).
// Optional FHN_SAT_STICKY_EN adds a sticky sat_flag output on the interface.
`default_nettype none

module fhn_array
  import fhn_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = DEF_FRAC,
  parameter int NUM_CH   = 8,
  parameter int DT_SHIFT = 4,
  parameter int A_Q      = DEF_A_Q,
  parameter int B_Q      = DEF_B_Q,
  parameter int EPS_Q    = DEF_EPS_Q,
  parameter int THIRD_Q  = DEF_THIRD_Q,
  parameter int V_TH     = 2048
) (
  input logic  clk,
  input logic  rst_n,
  fhn_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]         LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [WIDTH-1:0] V_TH_W  = WIDTH'(V_TH);

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;

  logic signed [WIDTH-1:0] v_mem_q [NUM_CH];
  logic signed [WIDTH-1:0] v_mem_d [NUM_CH];
  logic signed [WIDTH-1:0] w_mem_q [NUM_CH];
  logic signed [WIDTH-1:0] w_mem_d [NUM_CH];
  logic signed [WIDTH-1:0] i_mem_q [NUM_CH];
  logic signed [WIDTH-1:0] i_mem_d [NUM_CH];

  logic                    wr_ok;
  logic signed [WIDTH-1:0] i_load;
  logic signed [WIDTH-1:0] v_old, v_new, w_new;
  logic                    sat_v, sat_w;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          ch_d    = '0;
        end
      end
      LOAD: state_d = MUL1;
      MUL1: state_d = MUL2;
      MUL2: state_d = UPD;
      UPD:  state_d = WB;
      WB: begin
        if (ch_q == LAST_CH) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
          ch_d    = ch_q + CH_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_ok = bus.i_wr_en && (32'(bus.i_wr_addr) < NUM_CH);

  // A stimulus write landing in the LOAD cycle of the same channel is forwarded.
  assign i_load = (wr_ok && (bus.i_wr_addr == ch_q)) ? bus.i_wr_data : i_mem_q[ch_q];

  always_comb begin
    v_mem_d  = v_mem_q;
    w_mem_d  = w_mem_q;
    i_mem_d  = i_mem_q;
    out_ch_d = out_ch_q;
    if (state_q == WB) begin
      v_mem_d[ch_q] = v_new;
      w_mem_d[ch_q] = w_new;
    end
    if (wr_ok) begin
      i_mem_d[bus.i_wr_addr] = bus.i_wr_data;
    end
    if (state_q == UPD) begin
      out_ch_d = ch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      out_ch_q <= '0;
      v_mem_q  <= '{default: '0};
      w_mem_q  <= '{default: '0};
      i_mem_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      out_ch_q <= out_ch_d;
      v_mem_q  <= v_mem_d;
      w_mem_q  <= w_mem_d;
      i_mem_q  <= i_mem_d;
    end
  end

  fhn_euler_step #(
    .WIDTH   (WIDTH),
    .FRAC    (FRAC),
    .DT_SHIFT(DT_SHIFT),
    .A_Q     (A_Q),
    .B_Q     (B_Q),
    .EPS_Q   (EPS_Q),
    .THIRD_Q (THIRD_Q)
  ) u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_en  (state_q == LOAD),
    .mul1_en(state_q == MUL1),
    .mul2_en(state_q == MUL2),
    .upd_en (state_q == UPD),
    .v_in   (v_mem_q[ch_q]),
    .w_in   (w_mem_q[ch_q]),
    .i_in   (i_load),
    .v_old  (v_old),
    .v_new  (v_new),
    .w_new  (w_new),
    .sat_v  (sat_v),
    .sat_w  (sat_w)
  );

  // The datapath result registers double as the held output sample.
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.out_valid = (state_q == WB);
  assign bus.out_ch    = out_ch_q;
  assign bus.v_out     = v_new;
  assign bus.w_out     = w_new;
  assign bus.spike     = (state_q == WB) && (v_old < V_TH_W) && (v_new >= V_TH_W);

`ifdef FHN_SAT_STICKY_EN
  logic sat_flag_q, sat_flag_d;

  always_comb begin
    sat_flag_d = sat_flag_q | ((state_q == WB) & (sat_v | sat_w));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

  assign bus.sat_flag = sat_flag_q;
`else
  logic sat_unused;
  assign sat_unused = sat_v | sat_w;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fhn_array.sv
// tb_fhn_array: randomized scoreboard bench for fhn_array against an arithmetic FitzHugh-Nagumo model.
`default_nettype none

module tb_fhn_array;

  localparam int WIDTH    = 16;
  localparam int FRAC     = 12;
  localparam int NUM_CH   = 8;
  localparam int CH_W     = 3;
  localparam int DT_SHIFT = 4;
  localparam int A_Q      = 2867;
  localparam int B_Q      = 3277;
  localparam int EPS_Q    = 328;
  localparam int THIRD_Q  = 1365;
  localparam int V_TH     = 2048;
  localparam longint VMAX = (64'sd1 <<< (WIDTH - 1)) - 1;
  localparam longint VMIN = -(64'sd1 <<< (WIDTH - 1));

  typedef struct {
    int     ch;
    longint v;
    longint w;
    bit     sp;
  } exp_t;

  logic clk;
  logic rst_n;

  fhn_if #(.WIDTH(WIDTH), .CH_W(CH_W)) bus ();

  fhn_array #(
    .WIDTH(WIDTH), .FRAC(FRAC), .NUM_CH(NUM_CH), .DT_SHIFT(DT_SHIFT),
    .A_Q(A_Q), .B_Q(B_Q), .EPS_Q(EPS_Q), .THIRD_Q(THIRD_Q), .V_TH(V_TH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_total = 0;
  int     n_bad   = 0;
  exp_t   sb[$];
  longint mv [NUM_CH];
  longint mw [NUM_CH];
  longint mi [NUM_CH];
  bit     exp_sat;
  longint got_v [NUM_CH];
  longint got_w [NUM_CH];
  int     dut_spk;
  int     model_spk;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      mv[k] = 0;
      mw[k] = 0;
      mi[k] = 0;
    end
    exp_sat = 1'b0;
  endtask

  // One forward-Euler step of channel k in plain wide arithmetic.
  task automatic model_step(input int k, output exp_t e, output bit cl);
    longint v, w, i, sq, bw, cube, c3, dv, dw, vn, wn;
    v    = mv[k];
    w    = mw[k];
    i    = mi[k];
    sq   = (v * v) >>> FRAC;
    bw   = (B_Q * w) >>> FRAC;
    cube = (sq * v) >>> FRAC;
    c3   = (cube * THIRD_Q) >>> FRAC;
    dv   = v - c3 - w + i;
    dw   = (EPS_Q * (v + A_Q - bw)) >>> FRAC;
    vn   = v + (dv >>> DT_SHIFT);
    wn   = w + (dw >>> DT_SHIFT);
    cl   = 1'b0;
    if (vn > VMAX) begin vn = VMAX; cl = 1'b1; end
    if (vn < VMIN) begin vn = VMIN; cl = 1'b1; end
    if (wn > VMAX) begin wn = VMAX; cl = 1'b1; end
    if (wn < VMIN) begin wn = VMIN; cl = 1'b1; end
    e.ch  = k;
    e.v   = vn;
    e.w   = wn;
    e.sp  = (v < V_TH) && (vn >= V_TH);
    mv[k] = vn;
    mw[k] = wn;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_spike"},     bus.spike, 0);
    chk({tag, "_out_ch"},    bus.out_ch, 0);
    chk({tag, "_v_out"},     bus.v_out, 0);
    chk({tag, "_w_out"},     bus.w_out, 0);
  endtask

  // Entered and left at a negedge.
  task automatic do_reset(input int n);
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.i_wr_en   = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    chk_zero_outputs("reset");
  endtask

  task automatic write_stim(input int ch, input int val);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = CH_W'(ch);
    bus.i_wr_data = WIDTH'(val);
    mi[ch]        = val;
    @(negedge clk);
    bus.i_wr_en = 1'b0;
  endtask

  // Caller is at a negedge: that cycle is cycle 0 (start sampled at its end).
  task automatic sweep(input int bs_cyc, input int wr_cyc, input int wr_ch, input int wr_val,
                       input int rst_cyc);
    int   last;
    int   nvalid;
    bit   aborted;
    bit   cl;
    exp_t e;
    last = 5 * NUM_CH + 2;
    if (wr_cyc >= 0) mi[wr_ch] = wr_val;
    for (int k = 0; k < NUM_CH; k++) begin
      model_step(k, e, cl);
      sb.push_back(e);
      if (cl) exp_sat = 1'b1;
      if (k == 0 && e.sp) model_spk++;
    end
    bus.start = 1'b1;
    nvalid    = 0;
    aborted   = 1'b0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      bus.start   = (cyc == bs_cyc);
      bus.i_wr_en = (cyc == wr_cyc);
      if (cyc == wr_cyc) begin
        bus.i_wr_addr = CH_W'(wr_ch);
        bus.i_wr_data = WIDTH'(wr_val);
      end
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
      end else if (cyc == rst_cyc + 1) begin
        rst_n   = 1'b1;
        aborted = 1'b1;
        sb.delete();
        model_reset();
        chk_zero_outputs("abort");
      end
      if (aborted) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_valid", bus.out_valid, 0);
      end else begin
        chk("busy_timing",  bus.busy, (cyc <= 5 * NUM_CH + 1));
        chk("done_timing",  bus.done, (cyc == 5 * NUM_CH + 1));
        chk("valid_timing", bus.out_valid, ((cyc % 5) == 0) && (cyc <= 5 * NUM_CH));
      end
      if (bus.out_valid) nvalid++;
    end
    if (!aborted) chk("valid_count", nvalid, NUM_CH);
  endtask

  // Scoreboard monitor: pops one expectation per presented sample.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_sample: got ch %0d with empty scoreboard at %0t", bus.out_ch, $time);
      end else begin
        e = sb.pop_front();
        chk("sample_ch",    bus.out_ch, e.ch);
        chk("sample_v",     bus.v_out, e.v);
        chk("sample_w",     bus.w_out, e.w);
        chk("sample_spike", bus.spike, e.sp);
        got_v[bus.out_ch] = bus.v_out;
        got_w[bus.out_ch] = bus.w_out;
        if (bus.spike && bus.out_ch == 0) dut_spk++;
      end
    end else if (bus.spike) begin
      n_total++;
      n_bad++;
      $display("FAIL spike_without_valid: got 1 expected 0 at %0t", $time);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bs;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
    dut_spk       = 0;
    model_spk     = 0;
    model_reset();
    @(negedge clk);

    do_reset(3);
    sweep(-1, -1, 0, 0, -1);
    chk("first_ch0_v", got_v[0], 0);
    chk("first_ch0_w", got_w[0], 14);

    do_reset(1);
    write_stim(1, 4096);
    sweep(-1, -1, 0, 0, -1);
    chk("stim_ch1_v", got_v[1], 256);
    chk("stim_ch1_w", got_w[1], 14);
    chk("stim_ch5_v", got_v[5], 0);
    chk("stim_ch5_w", got_w[5], 14);

    sweep(12, -1, 0, 0, -1);
    sweep(-1, -1, 0, 0, -1);

    do_reset(1);
    sweep(-1, 16, 3, 4096, -1);
    chk("bypass_ch3_v", got_v[3], 256);

    do_reset(1);
    write_stim(0, 4096);
    dut_spk   = 0;
    model_spk = 0;
    repeat (400) sweep(-1, -1, 0, 0, -1);
    chk("spike_count_ch0", dut_spk, model_spk);

    sweep(-1, -1, 0, 0, 20);
    sweep(-1, -1, 0, 0, -1);
    chk("post_abort_ch0_v", got_v[0], 0);
    chk("post_abort_ch0_w", got_w[0], 14);

    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(1, 3)) write_stim($urandom_range(0, NUM_CH - 1),
                                               int'($urandom_range(0, 16383)) - 8192);
      bs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 5 * NUM_CH)) : -1;
      sweep(bs, -1, 0, 0, -1);
    end

`ifdef FHN_SAT_STICKY_EN
    do_reset(1);
    chk("sat_flag_reset", bus.sat_flag, 0);
    for (int k = 0; k < NUM_CH; k++) write_stim(k, 32767);
    for (int s = 0; s < 50; s++) begin
      sweep(-1, -1, 0, 0, -1);
      chk("sat_flag_sticky", bus.sat_flag, exp_sat);
    end
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
